// File: rtl/store_unit.sv
`default_nettype none
// ============================================================================
// Module   : store_unit
// Purpose  : Byte/half/word store engine with lane alignment. Define
//            STORE_SPLIT_EN to run stores that cross a word boundary as two
//            word writes; without it those stores are rejected with err.
// Revision : 1.0 - initial release
// ============================================================================
module store_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        done,
    output logic        err,
    output logic        mem_write,
    output logic [31:0] mem_address,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_byte_enable,
    input  logic        mem_resp
);

    localparam logic [2:0] c_F3_SB = 3'b000;
    localparam logic [2:0] c_F3_SH = 3'b001;
    localparam logic [2:0] c_F3_SW = 3'b010;

`ifdef STORE_SPLIT_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR0  = 2'd1,
        ST_WR1  = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR0  = 2'd1
    } state_t;
`endif

    function automatic logic [3:0] size_mask(input logic [2:0] f3);
        case (f3)
            c_F3_SB: size_mask = 4'b0001;
            c_F3_SH: size_mask = 4'b0011;
            c_F3_SW: size_mask = 4'b1111;
            default: size_mask = 4'b0000;
        endcase
    endfunction

    function automatic logic [31:0] size_data(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            c_F3_SB: size_data = {24'h0, d[7:0]};
            c_F3_SH: size_data = {16'h0, d[15:0]};
            c_F3_SW: size_data = d;
            default: size_data = 32'h0;
        endcase
    endfunction

    state_t      r_state;
    state_t      w_next_state;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic        r_done;
    logic        r_err;

    logic        w_accept;
    logic        w_next_done;
    logic        w_next_err;
    logic        w_req_legal;
    logic [7:0]  w_mask8;
    logic [63:0] w_data64;
    logic [31:0] w_word_addr;

    // Lane mask and data spread across two consecutive words, from the
    // captured request.
    assign w_mask8     = {4'b0000, size_mask(r_funct3)} << r_addr[1:0];
    assign w_data64    = {32'h0, size_data(r_funct3, r_wdata)} << {r_addr[1:0], 3'b000};
    assign w_word_addr = {r_addr[31:2], 2'b00};

`ifdef STORE_SPLIT_EN
    assign w_req_legal = (funct3 == c_F3_SB) || (funct3 == c_F3_SH) || (funct3 == c_F3_SW);
`else
    logic [7:0] w_req_mask8;
    logic       w_unused_hi;

    // Stores that would spill into the next word are illegal in this build.
    assign w_req_mask8 = {4'b0000, size_mask(funct3)} << addr[1:0];
    assign w_req_legal = (w_req_mask8 != 8'h00) && (w_req_mask8[7:4] == 4'b0000);
    assign w_unused_hi = ^{w_mask8[7:4], w_data64[63:32]};
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_funct3 <= 3'b000;
            r_addr   <= 32'h0;
            r_wdata  <= 32'h0;
        end else begin
            r_state <= w_next_state;
            r_done  <= w_next_done;
            r_err   <= w_next_err;
            if (w_accept) begin
                r_funct3 <= funct3;
                r_addr   <= addr;
                r_wdata  <= wdata;
            end
        end
    end

    always_comb begin
        w_next_state    = r_state;
        w_next_done     = 1'b0;
        w_next_err      = 1'b0;
        w_accept        = 1'b0;
        req_ready       = 1'b0;
        mem_write       = 1'b0;
        mem_address     = 32'h0;
        mem_wdata       = 32'h0;
        mem_byte_enable = 4'b0000;

        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_accept = 1'b1;
                    if (w_req_legal) begin
                        w_next_state = ST_WR0;
                    end else begin
                        w_next_err = 1'b1;
                    end
                end
            end
            ST_WR0: begin
                mem_write       = 1'b1;
                mem_address     = w_word_addr;
                mem_wdata       = w_data64[31:0];
                mem_byte_enable = w_mask8[3:0];
                if (mem_resp) begin
`ifdef STORE_SPLIT_EN
                    if (w_mask8[7:4] != 4'b0000) begin
                        w_next_state = ST_WR1;
                    end else begin
                        w_next_state = ST_IDLE;
                        w_next_done  = 1'b1;
                    end
`else
                    w_next_state = ST_IDLE;
                    w_next_done  = 1'b1;
`endif
                end
            end
`ifdef STORE_SPLIT_EN
            ST_WR1: begin
                mem_write       = 1'b1;
                mem_address     = w_word_addr + 32'd4;
                mem_wdata       = w_data64[63:32];
                mem_byte_enable = w_mask8[7:4];
                if (mem_resp) begin
                    w_next_state = ST_IDLE;
                    w_next_done  = 1'b1;
                end
            end
`endif
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    assign done = r_done;
    assign err  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_store_unit
// Purpose  : Directed self-checking bench for store_unit; expectations follow
//            STORE_SPLIT_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        done;
    logic        err;
    logic        mem_write;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_byte_enable;
    logic        mem_resp;

    int n_checks;
    int n_fail;

    store_unit dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .funct3          (funct3),
        .addr            (addr),
        .wdata           (wdata),
        .done            (done),
        .err             (err),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .mem_resp        (mem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present one request for a single clock; returns at the next negedge.
    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        req_valid = 1'b1;
        funct3    = f3;
        addr      = a;
        wdata     = d;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Checks one write beat for stall+1 cycles, then responds once.
    task automatic write_beat(input string tag, input logic [31:0] ea, input logic [3:0] eb,
                              input logic [31:0] ed, input int stall);
        for (int i = 0; i <= stall; i++) begin
            check_eq({tag, ".wr"},   mem_write, 1'b1);
            check_eq({tag, ".addr"}, mem_address, ea);
            check_eq({tag, ".be"},   mem_byte_enable, eb);
            check_eq({tag, ".data"}, mem_wdata, ed);
            check_eq({tag, ".rdy"},  req_ready, 1'b0);
            if (i == stall) mem_resp = 1'b1;
            @(negedge clk);
        end
        mem_resp = 1'b0;
    endtask

    task automatic expect_done(input string tag);
        check_eq({tag, ".done"}, done, 1'b1);
        check_eq({tag, ".err"},  err, 1'b0);
        check_eq({tag, ".idle_wr"}, mem_write, 1'b0);
        check_eq({tag, ".idle_be"}, mem_byte_enable, 4'b0000);
        check_eq({tag, ".idle_rdy"}, req_ready, 1'b1);
        @(negedge clk);
        check_eq({tag, ".done_clr"}, done, 1'b0);
    endtask

    task automatic expect_err(input string tag);
        check_eq({tag, ".err"},  err, 1'b1);
        check_eq({tag, ".done"}, done, 1'b0);
        check_eq({tag, ".wr"},   mem_write, 1'b0);
        check_eq({tag, ".rdy"},  req_ready, 1'b1);
        @(negedge clk);
        check_eq({tag, ".err_clr"}, err, 1'b0);
        check_eq({tag, ".wr2"},     mem_write, 1'b0);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        funct3    = 3'b000;
        addr      = 32'h0;
        wdata     = 32'h0;
        mem_resp  = 1'b0;

        repeat (2) @(negedge clk);
        check_eq("rst.rdy",  req_ready, 1'b1);
        check_eq("rst.done", done, 1'b0);
        check_eq("rst.err",  err, 1'b0);
        check_eq("rst.wr",   mem_write, 1'b0);
        check_eq("rst.addr", mem_address, 32'h0);
        check_eq("rst.data", mem_wdata, 32'h0);
        check_eq("rst.be",   mem_byte_enable, 4'b0000);
        rst_n = 1'b1;
        @(negedge clk);

        // sb into the top lane
        issue(3'b000, 32'h0000_1003, 32'hAABB_CCDD);
        write_beat("sb3", 32'h0000_1000, 4'b1000, 32'hDD00_0000, 1);
        expect_done("sb3");

        // sb at lane 0 masks off upper data bytes
        issue(3'b000, 32'h0000_6000, 32'hAABB_CCDD);
        write_beat("sb0", 32'h0000_6000, 4'b0001, 32'h0000_00DD, 0);
        expect_done("sb0");

        // sh upper half, with a competing request held during the access
        issue(3'b001, 32'h0000_2002, 32'h1234_BEEF);
        req_valid = 1'b1;
        funct3    = 3'b010;
        addr      = 32'h0000_9990;
        wdata     = 32'h5555_5555;
        write_beat("sh2", 32'h0000_2000, 4'b1100, 32'hBEEF_0000, 2);
        req_valid = 1'b0;
        expect_done("sh2");
        check_eq("sh2.no_accept", mem_write, 1'b0);

        // sh at offset 1 stays within one word
        issue(3'b001, 32'h0000_5001, 32'hFFFF_1234);
        write_beat("sh1", 32'h0000_5000, 4'b0110, 32'h0012_3400, 0);
        expect_done("sh1");

        // sw misaligned by one byte
        issue(3'b010, 32'h0000_3001, 32'h1122_3344);
`ifdef STORE_SPLIT_EN
        write_beat("sw1a", 32'h0000_3000, 4'b1110, 32'h2233_4400, 1);
        check_eq("sw1.mid_done", done, 1'b0);
        write_beat("sw1b", 32'h0000_3004, 4'b0001, 32'h0000_0011, 0);
        expect_done("sw1");
`else
        expect_err("sw1");
`endif

        // illegal funct3
        issue(3'b011, 32'h0000_8000, 32'h0BAD_0BAD);
        expect_err("f3_011");

        // sw straddling the top of the address space
        issue(3'b010, 32'hFFFF_FFFE, 32'hCAFE_F00D);
`ifdef STORE_SPLIT_EN
        write_beat("wrapa", 32'hFFFF_FFFC, 4'b1100, 32'hF00D_0000, 0);
        write_beat("wrapb", 32'h0000_0000, 4'b0011, 32'h0000_CAFE, 1);
        expect_done("wrap");
`else
        expect_err("wrap");
`endif

        // reset while a write is stalled
        issue(3'b010, 32'h0000_7000, 32'h0000_0055);
        for (int i = 0; i < 5; i++) begin
            check_eq("rstwr.wr", mem_write, 1'b1);
            @(negedge clk);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_eq("rstwr.wr0",  mem_write, 1'b0);
        check_eq("rstwr.done", done, 1'b0);
        check_eq("rstwr.rdy",  req_ready, 1'b1);
        check_eq("rstwr.addr", mem_address, 32'h0);
        mem_resp = 1'b1;
        @(negedge clk);
        mem_resp = 1'b0;
        check_eq("stray.done", done, 1'b0);
        check_eq("stray.wr",   mem_write, 1'b0);
        check_eq("stray.rdy",  req_ready, 1'b1);
        @(negedge clk);
        check_eq("stray.done2", done, 1'b0);

        // back-to-back sw: second request accepted in the done cycle
        issue(3'b010, 32'h0000_4000, 32'hA5A5_0001);
        write_beat("b2b1", 32'h0000_4000, 4'b1111, 32'hA5A5_0001, 1);
        check_eq("b2b1.done", done, 1'b1);
        check_eq("b2b1.rdy",  req_ready, 1'b1);
        issue(3'b010, 32'h0000_4004, 32'h5A5A_0002);
        check_eq("b2b2.done_clr", done, 1'b0);
        write_beat("b2b2", 32'h0000_4004, 4'b1111, 32'h5A5A_0002, 2);
        expect_done("b2b2");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/store_unit.md
STORE_UNIT -- requirements
Module: store_unit

Interface
REQ-001 The block SHALL have no parameters; the 32-bit data path width is fixed.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req_valid  input  1  store request presented.
REQ-005 req_ready  output  1  block idle and able to accept a request.
REQ-006 funct3  input  3  store type: sb=000, sh=001, sw=010; any other value is illegal.
REQ-007 addr  input  32  byte address of the store.
REQ-008 wdata  input  32  store data, right-justified (byte in [7:0], half in [15:0]).
REQ-009 done  output  1  one-cycle pulse: store finished successfully.
REQ-010 err  output  1  one-cycle pulse: store rejected and no memory access made.
REQ-011 mem_write  output  1  memory write strobe, held until mem_resp.
REQ-012 mem_address  output  32  word-aligned address, bits [1:0] always 00.
REQ-013 mem_wdata  output  32  lane-aligned write data.
REQ-014 mem_byte_enable  output  4  lane enables; bit i covers mem_wdata[8i+7:8i].
REQ-015 mem_resp  input  1  memory completed the current write this cycle.

Function
REQ-016 States SHALL be IDLE, WR0, WR1; req_ready SHALL be 1 only in IDLE.
REQ-017 In IDLE with req_valid=1, the block SHALL register funct3, addr and wdata; a legal request moves to WR0 on the next edge, and an illegal one raises err for the next cycle and stays in IDLE.
REQ-018 Let o=addr[1:0], size mask m = 0001 (sb), 0011 (sh) or 1111 (sw), 8-bit mask M = m<<o, and 64-bit data D = zero-extended data<<(8*o), where data is wdata masked to the store size.
REQ-019 WR0 SHALL drive mem_write=1, mem_address={addr[31:2],00}, mem_byte_enable=M[3:0] and mem_wdata=D[31:0]; disabled lanes SHALL be 0.
REQ-020 WR1 SHALL drive mem_write=1, mem_address={addr[31:2],00}+4 (wrapping 0xFFFFFFFC to 0x00000000), mem_byte_enable=M[7:4] and mem_wdata=D[63:32].
REQ-021 Outputs SHALL stay stable while mem_write=1 and mem_resp=0; there is no timeout.
REQ-022 On mem_resp in WR0, the block SHALL go to WR1 if M[7:4]!=0, otherwise to IDLE.
REQ-023 On mem_resp in WR1, the block SHALL go to IDLE.
REQ-024 done SHALL be 1 for exactly the first IDLE cycle after the final mem_resp.
REQ-025 A request may be accepted in that same cycle, giving back-to-back throughput.
REQ-026 mem_resp SHALL be ignored in IDLE, and req_valid SHALL be ignored outside IDLE.
REQ-027 In IDLE, mem_write, mem_byte_enable and mem_wdata SHALL be 0.
REQ-028 done and err SHALL never be 1 in the same cycle.

Reset
REQ-029 With rst_n=0 at a clock edge, the next state SHALL be IDLE with req_ready=1 and done=err=mem_write=0; mem_address, mem_wdata and mem_byte_enable SHALL be 0.
REQ-030 Reset during WR0 or WR1 SHALL abandon the access with no done pulse; a mem_resp arriving after reset SHALL be ignored.

Configuration
REQ-031 With STORE_SPLIT_EN defined, stores with M[7:4]!=0 (sh at o=3; sw at o=1,2,3) SHALL be executed as two accesses as specified in REQ-020 and REQ-022.
REQ-032 Without STORE_SPLIT_EN, such stores SHALL be rejected via err per REQ-017, WR1 SHALL not exist, and sh at o=1 SHALL still complete as a single access.

Verification
REQ-033 sb, addr=0x1003, wdata=0xAABBCCDD -> single write to 0x1000, be=1000, mem_wdata=0xDD000000; done one cycle after mem_resp.
REQ-034 sh, addr=0x2002, wdata=0x1234BEEF -> write to 0x2000, be=1100, mem_wdata=0xBEEF0000.
REQ-035 sw, addr=0x3001, wdata=0x11223344, split enabled -> write 0x3000 be=1110 data=0x22334400, then write 0x3004 be=0001 data=0x00000011; single done; without the macro -> err pulse and no mem_write.
REQ-036 funct3=011 -> err pulse the next cycle and no mem_write; then sw to 0xFFFFFFFE (split enabled) -> second access to address 0x00000000 with be=0011.
REQ-037 Assert rst_n=0 during WR0 while mem_resp is held low for 5 cycles -> IDLE with mem_write=0 and no done; a stray mem_resp afterwards causes no change.
REQ-038 Two back-to-back sw requests at 0x4000 and 0x4004 -> second accepted in the done cycle, and each write waits for its own mem_resp.
